// File: rtl/fib_engine.sv
// Multi-round Fibonacci engine: accepts an index n, iterates UNROLL rounds per clock,
// and returns fib(n) with wrap or saturate arithmetic plus an overflow flag.
module fib_engine #(
  parameter int WIDTH  = 8,
  parameter int NW     = 8,
  parameter int UNROLL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NW-1:0]    n_in,
  input  logic             sat_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a, b, a_nxt, b_nxt, res_nxt;
  logic               a_ovf, b_ovf, a_ovf_nxt, b_ovf_nxt, ovf_nxt;
  logic [NW-1:0]      i, n_r, i_nxt, n_nxt;
  logic               sat_r, sat_nxt;

  logic [WIDTH-1:0]   rnd_a, rnd_b;
  logic               rnd_a_ovf, rnd_b_ovf;
  logic [NW-1:0]      rnd_i;
  logic [WIDTH:0]     sum;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN);

  // Chained rounds for one RUN cycle; the i<n_r guard makes surplus rounds no-ops
  // and keeps i from ever wrapping past n_r.
  always_comb begin
    rnd_a     = a;
    rnd_b     = b;
    rnd_i     = i;
    rnd_a_ovf = a_ovf;
    rnd_b_ovf = b_ovf;
    sum       = {(WIDTH+1){1'b0}};
    for (int k = 0; k < UNROLL; k++) begin
      if (rnd_i < n_r) begin
        sum       = {1'b0, rnd_a} + {1'b0, rnd_b};
        rnd_a     = rnd_b;
        rnd_a_ovf = rnd_b_ovf;
        rnd_b     = (sat_r && sum[WIDTH]) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
        rnd_b_ovf = rnd_b_ovf | sum[WIDTH];
        rnd_i     = rnd_i + {{(NW-1){1'b0}}, 1'b1};
      end else begin
        rnd_i     = rnd_i;
      end
    end
  end

  // Next-state and datapath update; res/ovf only change when a job completes.
  always_comb begin
    state_nxt = state;
    a_nxt     = a;
    b_nxt     = b;
    a_ovf_nxt = a_ovf;
    b_ovf_nxt = b_ovf;
    i_nxt     = i;
    n_nxt     = n_r;
    sat_nxt   = sat_r;
    res_nxt   = res;
    ovf_nxt   = ovf;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_nxt     = {WIDTH{1'b0}};
            b_nxt     = {{(WIDTH-1){1'b0}}, 1'b1};
            a_ovf_nxt = 1'b0;
            b_ovf_nxt = 1'b0;
            i_nxt     = {NW{1'b0}};
            n_nxt     = n_in;
            sat_nxt   = sat_in;
            if (n_in == {NW{1'b0}}) begin
              state_nxt = DONE;
              res_nxt   = {WIDTH{1'b0}};
              ovf_nxt   = 1'b0;
            end else begin
              state_nxt = RUN;
            end
          end else begin
            state_nxt = IDLE;
          end
        end
        RUN: begin
          a_nxt     = rnd_a;
          b_nxt     = rnd_b;
          a_ovf_nxt = rnd_a_ovf;
          b_ovf_nxt = rnd_b_ovf;
          i_nxt     = rnd_i;
          if (rnd_i == n_r) begin
            state_nxt = DONE;
            res_nxt   = rnd_a;
            ovf_nxt   = rnd_a_ovf;
          end else begin
            state_nxt = RUN;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = DONE;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a     <= {WIDTH{1'b0}};
      b     <= {WIDTH{1'b0}};
      a_ovf <= 1'b0;
      b_ovf <= 1'b0;
      i     <= {NW{1'b0}};
      n_r   <= {NW{1'b0}};
      sat_r <= 1'b0;
      res   <= {WIDTH{1'b0}};
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      a     <= a_nxt;
      b     <= b_nxt;
      a_ovf <= a_ovf_nxt;
      b_ovf <= b_ovf_nxt;
      i     <= i_nxt;
      n_r   <= n_nxt;
      sat_r <= sat_nxt;
      res   <= res_nxt;
      ovf   <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_fib_engine.sv
// Directed bench for fib_engine: one UNROLL=1 instance plus UNROLL=4 and UNROLL=3 instances.
module tb_fib_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] n_in = 8'd0;
  logic       sat_in = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] res;
  logic       ovf;
  logic       busy;

  logic       u_valid = 1'b0;
  logic [7:0] n4 = 8'd0, n3 = 8'd0;
  logic       in_ready4, in_ready3, out_valid4, out_valid3, ovf4, ovf3, busy4, busy3;
  logic [7:0] res4, res3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fib_engine #(.WIDTH(8), .NW(8), .UNROLL(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .n_in(n_in), .sat_in(sat_in), .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .ovf(ovf), .busy(busy)
  );

  fib_engine #(.WIDTH(8), .NW(8), .UNROLL(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .clear(1'b0), .in_valid(u_valid), .in_ready(in_ready4),
    .n_in(n4), .sat_in(1'b0), .out_valid(out_valid4), .out_ready(1'b0),
    .res(res4), .ovf(ovf4), .busy(busy4)
  );

  fib_engine #(.WIDTH(8), .NW(8), .UNROLL(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .clear(1'b0), .in_valid(u_valid), .in_ready(in_ready3),
    .n_in(n3), .sat_in(1'b0), .out_valid(out_valid3), .out_ready(1'b0),
    .res(res3), .ovf(ovf3), .busy(busy3)
  );

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [7:0] n, input logic sat);
    in_valid = 1'b1;
    n_in     = n;
    sat_in   = sat;
    tick();
    in_valid = 1'b0;
  endtask

  // Count edges after the accept edge until out_valid rises (bounded).
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 400) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_job(input string tag, input logic [7:0] n, input logic sat,
                         input logic [7:0] exp_res, input logic exp_ovf, input int exp_lat);
    int lat;
    req(n, sat);
    wait_done(lat);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_res"}, res, exp_res);
    chk({tag, "_ovf"}, ovf, exp_ovf);
    chk({tag, "_inrdy_done"}, in_ready, 1'b0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, out_valid, 1'b0);
    chk({tag, "_inrdy_idle"}, in_ready, 1'b1);
  endtask

  initial begin
    int lat;
    int lat4, lat3;
    logic [7:0] r4, r3;

    tick();
    tick();
    chk("rst_res", res, 8'd0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_inrdy", in_ready, 1'b1);
    rst_n = 1'b1;
    tick();

    run_job("n10", 8'd10, 1'b0, 8'd55, 1'b0, 10);
    run_job("n0", 8'd0, 1'b0, 8'd0, 1'b0, 0);
    run_job("n1", 8'd1, 1'b0, 8'd1, 1'b0, 1);
    run_job("n14w", 8'd14, 1'b0, 8'd121, 1'b1, 14);
    run_job("n14s", 8'd14, 1'b1, 8'd255, 1'b1, 14);
    run_job("n13", 8'd13, 1'b0, 8'd233, 1'b0, 13);
    run_job("n255s", 8'd255, 1'b1, 8'd255, 1'b1, 255);

    // Back-pressure in DONE
    req(8'd5, 1'b0);
    chk("bp_busy", busy, 1'b1);
    wait_done(lat);
    chk("bp_lat", lat, 5);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_res", res, 8'd5);
      chk("bp_ovf", ovf, 1'b0);
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_inrdy", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_rel_inrdy", in_ready, 1'b1);
    req(8'd2, 1'b0);
    chk("bp_next_busy", busy, 1'b1);
    wait_done(lat);
    chk("bp_next_lat", lat, 2);
    chk("bp_next_res", res, 8'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // clear mid-RUN beats a simultaneous request
    req(8'd20, 1'b0);
    tick();
    tick();
    chk("clr_busy_before", busy, 1'b1);
    clear    = 1'b1;
    in_valid = 1'b1;
    n_in     = 8'd3;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clr_inrdy", in_ready, 1'b1);
    chk("clr_busy", busy, 1'b0);
    chk("clr_valid", out_valid, 1'b0);
    chk("clr_res_kept", res, 8'd1);
    tick();
    chk("clr_no_accept", busy, 1'b0);
    chk("clr_no_accept_inrdy", in_ready, 1'b1);

    // clear together with out_ready in DONE
    req(8'd3, 1'b0);
    wait_done(lat);
    chk("clrd_res", res, 8'd2);
    clear     = 1'b1;
    out_ready = 1'b1;
    tick();
    clear     = 1'b0;
    out_ready = 1'b0;
    chk("clrd_valid", out_valid, 1'b0);
    chk("clrd_inrdy", in_ready, 1'b1);
    chk("clrd_res_kept", res, 8'd2);

    // async reset mid-RUN
    req(8'd30, 1'b0);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_res", res, 8'd0);
    chk("arst_ovf", ovf, 1'b0);
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_inrdy", in_ready, 1'b1);
    tick();
    rst_n = 1'b1;
    tick();

    // Unrolled instances
    n4      = 8'd10;
    n3      = 8'd7;
    u_valid = 1'b1;
    tick();
    u_valid = 1'b0;
    lat4 = -1;
    lat3 = -1;
    r4 = 8'd0;
    r3 = 8'd0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (out_valid4 && lat4 < 0) begin
        lat4 = k;
        r4   = res4;
      end
      if (out_valid3 && lat3 < 0) begin
        lat3 = k;
        r3   = res3;
      end
    end
    chk("u4_lat", lat4, 3);
    chk("u4_res", r4, 8'd55);
    chk("u4_ovf", ovf4, 1'b0);
    chk("u3_lat", lat3, 3);
    chk("u3_res", r3, 8'd13);
    chk("u3_ovf", ovf3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
